// File: rtl/lsu_pkg.sv
// Shared encodings, constants and lane helpers for the MEM-stage load/store unit.
package lsu_pkg;

  localparam int WORD_BYTES    = 4;
  localparam int DEFAULT_DEPTH = 128;

  typedef enum logic [2:0] {
    OP_LB  = 3'b000,
    OP_LH  = 3'b001,
    OP_LW  = 3'b010,
    OP_LBU = 3'b100,
    OP_LHU = 3'b101
  } op_e;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10
  } size_e;

  typedef enum logic {
    IDLE  = 1'b0,
    MERGE = 1'b1
  } state_e;

  // op[2] selects zero-extension; op[1:0] is the access size
  function automatic logic [31:0] extend_load(input logic [31:0] word, input logic [2:0] op,
                                              input logic [1:0] lane);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    b = word[{lane, 3'b000} +: 8];
    h = word[{lane[1], 4'b0000} +: 16];
    case (op[1:0])
      SZ_B:    res = op[2] ? {24'h0, b} : {{24{b[7]}}, b};
      SZ_H:    res = op[2] ? {16'h0, h} : {{16{h[15]}}, h};
      default: res = word;
    endcase
    return res;
  endfunction

  function automatic logic [31:0] merge_store(input logic [31:0] word, input logic [31:0] wdata,
                                              input logic [1:0] size, input logic [1:0] lane);
    logic [31:0] res;
    res = word;
    case (size)
      SZ_B:    res[{lane, 3'b000} +: 8] = wdata[7:0];
      SZ_H:    res[{lane[1], 4'b0000} +: 16] = wdata[15:0];
      default: res = wdata;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Lane select/extension for loads and lane merge for sub-word stores; purely combinational.
import lsu_pkg::*;

module lsu_lane_align (
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  input  logic [2:0]  op,
  input  logic [1:0]  lane,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);

  assign load_data  = extend_load(word, op, lane);
  assign merge_data = merge_store(word, wdata, op[1:0], lane);

endmodule

// File: rtl/lsu_mem_stage.sv
// MEM-stage load/store unit: alignment/range checks, RMW for sub-word stores, registered load response.
// state | meaning
// IDLE  | accepting requests; loads and SW complete here, SB/SH read the old word
// MERGE | writing back the merged word for SB/SH; upstream stalled
import lsu_pkg::*;

module lsu_mem_stage #(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [31:0] Address,
  output logic [31:0] WriteData,
  input  logic [31:0] ReadData
);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q;
  logic [1:0]         lane_q;
  logic [1:0]         size_q;
  logic [15:0]        wdata_q;
  logic [31:0]        merge_q;

  logic               accept, is_word, misaligned, out_of_range, err;
  logic [31:0]        align_word, align_wdata, load_data, merge_data;
  logic [2:0]         align_op;
  logic [1:0]         align_lane;

  assign req_ready    = (state_q == IDLE) && !Reset;
  assign accept       = req_valid && req_ready;
  assign is_word      = req_op[1];
  assign misaligned   = ((req_op[1:0] == SZ_H) && req_addr[0]) || (is_word && (req_addr[1:0] != 2'b00));
  assign out_of_range = req_addr >= 32'(DEPTH * WORD_BYTES);
  assign err          = misaligned || out_of_range;

  lsu_lane_align u_align (
    .word       (align_word),
    .wdata      (align_wdata),
    .op         (align_op),
    .lane       (align_lane),
    .load_data  (load_data),
    .merge_data (merge_data)
  );

  always_comb begin
    state_d     = state_q;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    Address     = {{(32-IDX_W){1'b0}}, req_addr[IDX_W+1:2]};
    WriteData   = req_wdata;
    align_word  = ReadData;
    align_wdata = req_wdata;
    align_op    = req_op;
    align_lane  = req_addr[1:0];
    case (state_q)
      IDLE: begin
        if (accept && !err) begin
          if (req_store && is_word) begin
            MemWrite = 1'b1;
          end else begin
            MemRead = 1'b1;
            if (req_store) state_d = MERGE;
          end
        end
      end
      MERGE: begin
        align_word  = merge_q;
        align_wdata = {16'h0, wdata_q};
        align_op    = {1'b0, size_q};
        align_lane  = lane_q;
        Address     = {{(32-IDX_W){1'b0}}, idx_q};
        WriteData   = merge_data;
        MemWrite    = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Reset kills any in-flight merge write immediately, not at the next edge
    if (Reset) begin
      MemRead   = 1'b0;
      MemWrite  = 1'b0;
      Address   = 32'h0;
      WriteData = 32'h0;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      lane_q    <= 2'b00;
      size_q    <= 2'b00;
      wdata_q   <= 16'h0;
      merge_q   <= 32'h0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= 32'h0;
    end else begin
      state_q   <= state_d;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= 32'h0;
      if (state_q == MERGE) begin
        rsp_valid <= 1'b1;
      end else if (accept) begin
        if (err) begin
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b1;
        end else if (!req_store) begin
          rsp_valid <= 1'b1;
          rsp_rdata <= load_data;
        end else if (is_word) begin
          rsp_valid <= 1'b1;
        end else begin
          idx_q   <= req_addr[IDX_W+1:2];
          lane_q  <= req_addr[1:0];
          size_q  <= req_op[1:0];
          wdata_q <= req_wdata[15:0];
          merge_q <= ReadData;
        end
      end
    end
  end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Randomized self-checking bench for lsu_mem_stage against a byte-array memory model.
module tb_lsu_mem_stage;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        req_valid = 1'b0, req_store = 1'b0;
  logic [2:0]  req_op = 3'b000;
  logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
  logic        req_ready, rsp_valid, rsp_err, MemRead, MemWrite;
  logic [31:0] rsp_rdata, Address, WriteData, ReadData;

  always #5 Clk = ~Clk;

  lsu_mem_stage dut (
    .Clk(Clk), .Reset(Reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .MemRead(MemRead), .MemWrite(MemWrite), .Address(Address),
    .WriteData(WriteData), .ReadData(ReadData)
  );

  // data memory seen by the DUT
  logic [31:0] mem [0:127];
  initial for (int i = 0; i < 128; i++) mem[i] <= 32'h0;
  assign ReadData = mem[Address[6:0]];
  always @(posedge Clk) if (MemWrite) mem[Address[6:0]] <= WriteData;

  // reference: byte-addressed memory plus queue of expected responses
  typedef struct {
    int          due;
    logic        err;
    logic [31:0] rdata;
  } rsp_t;

  rsp_t       exp_q [$];
  logic [7:0] ref_mem [0:511];
  int         cyc = 0;
  logic       merge_pending = 1'b0;
  int         merge_idx = 0;
  int         n_total = 0;
  int         n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ref_word(input int i);
    return {ref_mem[4*i+3], ref_mem[4*i+2], ref_mem[4*i+1], ref_mem[4*i]};
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] op, input int a);
    logic [15:0] h;
    h = {ref_mem[a+1], ref_mem[a]};
    case (op)
      3'b000:  return {{24{ref_mem[a][7]}}, ref_mem[a]};
      3'b100:  return {24'h0, ref_mem[a]};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'h0, h};
      default: return ref_word(a / 4);
    endcase
  endfunction

  // one clock cycle: check responses, present a request, check strobes
  task automatic tick(input logic v, input logic st, input logic [2:0] op,
                      input logic [31:0] a, input logic [31:0] wd, output logic acc);
    rsp_t r;
    logic merge_now, exp_rd, exp_wr, bad;
    int   sz, base;
    @(negedge Clk);
    cyc++;
    if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
      r = exp_q.pop_front();
      check_val("rsp_valid", {31'h0, rsp_valid}, 32'h1);
      check_val("rsp_err", {31'h0, rsp_err}, {31'h0, r.err});
      check_val("rsp_rdata", rsp_rdata, r.rdata);
    end else begin
      check_val("rsp_valid_quiet", {31'h0, rsp_valid}, 32'h0);
    end
    req_valid = v; req_store = st; req_op = op; req_addr = a; req_wdata = wd;
    #1;
    merge_now = merge_pending;
    merge_pending = 1'b0;
    check_val("req_ready", {31'h0, req_ready}, {31'h0, !merge_now});
    acc = v && !merge_now;
    exp_rd = 1'b0;
    exp_wr = 1'b0;
    if (merge_now) begin
      exp_wr = 1'b1;
      check_val("merge_addr", Address, 32'(merge_idx));
      check_val("merge_wdata", WriteData, ref_word(merge_idx));
    end
    if (acc) begin
      sz = int'(op[1:0]);
      bad = (sz == 1 && a[0]) || (sz == 2 && a[1:0] != 2'b00) || (a >= 32'd512);
      base = int'(a[8:0]);
      if (bad) begin
        exp_q.push_back('{due: cyc + 1, err: 1'b1, rdata: 32'h0});
      end else if (!st) begin
        exp_rd = 1'b1;
        check_val("load_addr", Address, 32'(base / 4));
        exp_q.push_back('{due: cyc + 1, err: 1'b0, rdata: ref_load(op, base)});
      end else begin
        for (int k = 0; k < (1 << sz); k++) ref_mem[base + k] = wd[8*k +: 8];
        check_val("store_addr", Address, 32'(base / 4));
        if (sz == 2) begin
          exp_wr = 1'b1;
          check_val("sw_wdata", WriteData, wd);
          exp_q.push_back('{due: cyc + 1, err: 1'b0, rdata: 32'h0});
        end else begin
          exp_rd = 1'b1;
          merge_pending = 1'b1;
          merge_idx = base / 4;
          exp_q.push_back('{due: cyc + 2, err: 1'b0, rdata: 32'h0});
        end
      end
    end
    check_val("MemRead", {31'h0, MemRead}, {31'h0, exp_rd});
    check_val("MemWrite", {31'h0, MemWrite}, {31'h0, exp_wr});
  endtask

  task automatic send(input logic st, input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd);
    logic acc;
    int   n;
    n = 0;
    do begin
      tick(1'b1, st, op, a, wd, acc);
      n++;
    end while (!acc && n < 8);
    check_val("accept_timeout", {31'h0, acc}, 32'h1);
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, acc);
  endtask

  initial begin
    logic [2:0]  lops [5];
    logic [31:0] a, saved;
    logic        acc;
    lops = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    for (int i = 0; i < 512; i++) ref_mem[i] = 8'h00;

    #1 Reset = 1'b1;
    @(negedge Clk); @(negedge Clk);
    check_val("rst_ready", {31'h0, req_ready}, 32'h0);
    check_val("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check_val("rst_rsp_err", {31'h0, rsp_err}, 32'h0);
    check_val("rst_rsp_rdata", rsp_rdata, 32'h0);
    check_val("rst_memrd", {31'h0, MemRead}, 32'h0);
    check_val("rst_memwr", {31'h0, MemWrite}, 32'h0);
    Reset = 1'b0;

    // directed scenarios
    send(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
    idle(1);
    check_val("t1_word4", mem[4], 32'hDEADBEEF);
    send(1'b0, 3'b000, 32'h11, 32'h0);
    send(1'b0, 3'b100, 32'h11, 32'h0);
    send(1'b0, 3'b001, 32'h12, 32'h0);
    send(1'b0, 3'b101, 32'h12, 32'h0);
    send(1'b0, 3'b010, 32'h10, 32'h0);
    idle(1);
    send(1'b1, 3'b000, 32'h13, 32'h00000012);
    send(1'b1, 3'b001, 32'h10, 32'h0000CAFE);
    idle(3);
    check_val("t3_word4", mem[4], 32'h12ADCAFE);
    send(1'b0, 3'b010, 32'h06, 32'h0);
    send(1'b1, 3'b001, 32'h11, 32'h0000BEEF);
    send(1'b0, 3'b010, 32'h200, 32'h0);
    send(1'b0, 3'b010, 32'h1FC, 32'h0);
    idle(2);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 7))
        0:       a = 32'h200 + $urandom_range(0, 255);
        1:       a = $urandom;
        2, 3, 4: a = $urandom_range(0, 63);
        default: a = $urandom_range(0, 511);
      endcase
      if ($urandom_range(0, 3) == 0) idle(1);
      else if ($urandom_range(0, 1) == 0) send(1'b1, 3'($urandom_range(0, 2)), a, $urandom);
      else send(1'b0, lops[$urandom_range(0, 4)], a, 32'h0);
    end
    idle(3);
    check_val("drain", 32'(exp_q.size()), 32'h0);
    for (int i = 0; i < 128; i++) check_val("mem_final", mem[i], ref_word(i));

    // reset during the merge cycle of an SB drops the write and the response
    saved = ref_word(4);
    tick(1'b1, 1'b1, 3'b000, 32'h10, 32'h000000AA, acc);
    @(negedge Clk);
    cyc++;
    req_valid = 1'b0;
    Reset = 1'b1;
    #1;
    check_val("mr_ready", {31'h0, req_ready}, 32'h0);
    check_val("mr_memwr", {31'h0, MemWrite}, 32'h0);
    check_val("mr_memrd", {31'h0, MemRead}, 32'h0);
    check_val("mr_addr", Address, 32'h0);
    check_val("mr_wdata", WriteData, 32'h0);
    check_val("mr_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check_val("mr_rsp_rdata", rsp_rdata, 32'h0);
    @(negedge Clk);
    cyc++;
    Reset = 1'b0;
    #1;
    check_val("post_rst_ready", {31'h0, req_ready}, 32'h1);
    check_val("post_rst_rsp", {31'h0, rsp_valid}, 32'h0);
    check_val("mr_word4", mem[4], saved);
    for (int k = 0; k < 4; k++) ref_mem[16 + k] = saved[8*k +: 8];
    exp_q.delete();
    merge_pending = 1'b0;
    send(1'b0, 3'b010, 32'h10, 32'h0);
    idle(2);
    check_val("end_drain", 32'(exp_q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
